// File: rtl/scroll_seq.sv
// Scrolling-runner sequencer: frame timing from vsync, debounced start button,
// IDLE/RUN/OVER game flow, background scroll offset, speed ramp and score.
module scroll_seq #(
  parameter int unsigned SPEED_MIN   = 1,
  parameter int unsigned SPEED_MAX   = 4,
  parameter int unsigned RAMP_FRAMES = 512,
  parameter int unsigned HOLD_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic        btn,
  input  logic        collision,
  output logic        start,
  output logic        game_over,
  output logic [9:0]  scroll_offset,
  output logic [2:0]  speed,
  output logic        star_phase,
  output logic [13:0] score
);

  localparam int unsigned RAMP_W = (RAMP_FRAMES > 2) ? $clog2(RAMP_FRAMES) : 1;
  localparam int unsigned HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_RUN  = 2'd1;
  localparam logic [1:0]  S_OVER = 2'd2;

  localparam logic [13:0] SCORE_MAX = 14'd9999;

  logic              vs_meta, vs_sync, vs_prev;
  logic              btn_meta, btn_sync;
  logic [1:0]        btn_hist;
  logic              frame_tick_c;
  logic              btn_press_c;

  logic [1:0]        state, state_nxt;
  logic              start_nxt, game_over_nxt;
  logic [9:0]        offset_nxt;
  logic [2:0]        speed_nxt;
  logic              star_nxt;
  logic [13:0]       score_nxt;
  logic [RAMP_W-1:0] ramp_cnt, ramp_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;

  // Input synchronisers; button history advances once per frame (bit 0 newest)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_meta  <= 1'b0;
      vs_sync  <= 1'b0;
      vs_prev  <= 1'b0;
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      btn_hist <= 2'b00;
    end else begin
      vs_meta  <= vsync;
      vs_sync  <= vs_meta;
      vs_prev  <= vs_sync;
      btn_meta <= btn;
      btn_sync <= btn_meta;
      if (frame_tick_c) begin
        btn_hist <= {btn_hist[0], btn_sync};
      end
    end
  end

  assign frame_tick_c = vs_sync & ~vs_prev;
  // Press = low, high, high on three consecutive frame samples
  assign btn_press_c  = frame_tick_c & btn_sync & btn_hist[0] & ~btn_hist[1];

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      start         <= 1'b0;
      game_over     <= 1'b0;
      scroll_offset <= 10'd0;
      speed         <= 3'(SPEED_MIN);
      star_phase    <= 1'b0;
      score         <= 14'd0;
      ramp_cnt      <= '0;
      hold_cnt      <= '0;
    end else begin
      state         <= state_nxt;
      start         <= start_nxt;
      game_over     <= game_over_nxt;
      scroll_offset <= offset_nxt;
      speed         <= speed_nxt;
      star_phase    <= star_nxt;
      score         <= score_nxt;
      ramp_cnt      <= ramp_nxt;
      hold_cnt      <= hold_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt  = state;
    offset_nxt = scroll_offset;
    speed_nxt  = speed;
    score_nxt  = score;
    ramp_nxt   = ramp_cnt;
    hold_nxt   = hold_cnt;
    star_nxt   = star_phase ^ frame_tick_c;

    case (state)
      S_IDLE: begin
        if (btn_press_c) begin
          state_nxt  = S_RUN;
          offset_nxt = 10'd0;
          score_nxt  = 14'd0;
          speed_nxt  = 3'(SPEED_MIN);
          ramp_nxt   = '0;
        end
      end
      S_RUN: begin
        // Collision wins over a coincident frame update
        if (collision) begin
          state_nxt = S_OVER;
          hold_nxt  = '0;
        end else if (frame_tick_c) begin
          offset_nxt = scroll_offset + 10'(speed);
          score_nxt  = (score >= SCORE_MAX) ? score : score + 14'd1;
          if (ramp_cnt == RAMP_W'(RAMP_FRAMES - 1)) begin
            ramp_nxt  = '0;
            speed_nxt = (speed >= 3'(SPEED_MAX)) ? speed : speed + 3'd1;
          end else begin
            ramp_nxt = ramp_cnt + RAMP_W'(1);
          end
        end
      end
      S_OVER: begin
        if (frame_tick_c) begin
          if (btn_press_c && (hold_cnt == HOLD_W'(HOLD_FRAMES))) begin
            state_nxt = S_IDLE;
          end else if (hold_cnt != HOLD_W'(HOLD_FRAMES)) begin
            hold_nxt = hold_cnt + HOLD_W'(1);
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    start_nxt     = (state_nxt == S_RUN);
    game_over_nxt = (state_nxt == S_OVER);
  end

endmodule

// File: tb/tb_scroll_seq.sv
// Directed + randomized bench for scroll_seq against a frame-level reference model.
module tb_scroll_seq;

  localparam int SPEED_MIN = 1;
  localparam int SPEED_MAX = 4;
  localparam int RAMP      = 512;
  localparam int HOLD      = 60;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_OVER = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vsync;
  logic        btn;
  logic        collision;
  logic        start;
  logic        game_over;
  logic [9:0]  scroll_offset;
  logic [2:0]  speed;
  logic        star_phase;
  logic [13:0] score;

  always #5 clk = ~clk;

  scroll_seq #(
    .SPEED_MIN  (SPEED_MIN),
    .SPEED_MAX  (SPEED_MAX),
    .RAMP_FRAMES(RAMP),
    .HOLD_FRAMES(HOLD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vsync        (vsync),
    .btn          (btn),
    .collision    (collision),
    .start        (start),
    .game_over    (game_over),
    .scroll_offset(scroll_offset),
    .speed        (speed),
    .star_phase   (star_phase),
    .score        (score)
  );

  int checks = 0;
  int errors = 0;

  // Reference model, one update per video frame
  int m_st, m_off, m_score, m_speed, m_runf, m_hold;
  bit m_star, h1, h2;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_off = 0; m_score = 0; m_speed = SPEED_MIN;
    m_runf = 0; m_hold = 0; m_star = 0; h1 = 0; h2 = 0;
  endtask

  function automatic int ramp_speed(input int frames);
    int s;
    s = SPEED_MIN + frames / RAMP;
    return (s > SPEED_MAX) ? SPEED_MAX : s;
  endfunction

  // cmode: 0 none, 1 collision on the frame tick, 2 collision before the tick
  task automatic model_frame(input bit b, input int cmode);
    bit press;
    if (cmode == 2 && m_st == M_RUN) begin
      m_st = M_OVER; m_hold = 0;
    end
    m_star = ~m_star;
    press = b && h1 && !h2;
    h2 = h1; h1 = b;
    if (cmode == 1 && m_st == M_RUN) begin
      m_st = M_OVER; m_hold = 0;
    end else if (m_st == M_IDLE) begin
      if (press) begin
        m_st = M_RUN; m_runf = 0; m_off = 0; m_score = 0; m_speed = SPEED_MIN;
      end
    end else if (m_st == M_RUN) begin
      m_off   = (m_off + ramp_speed(m_runf)) % 1024;
      m_runf  = m_runf + 1;
      m_score = (m_runf > 9999) ? 9999 : m_runf;
      m_speed = ramp_speed(m_runf);
    end else begin
      if (press && m_hold == HOLD) m_st = M_IDLE;
      else if (m_hold < HOLD) m_hold = m_hold + 1;
    end
  endtask

  task automatic check_model();
    check("start",     32'(start),         int'(m_st == M_RUN));
    check("game_over", 32'(game_over),     int'(m_st == M_OVER));
    check("offset",    32'(scroll_offset), m_off);
    check("speed",     32'(speed),         m_speed);
    check("star",      32'(star_phase),    int'(m_star));
    check("score",     32'(score),         m_score);
  endtask

  // One video frame; called and returns on a falling clock edge
  task automatic frame(input bit b, input int cmode);
    int lo, hi;
    lo = $urandom_range(4, 7);
    hi = $urandom_range(4, 7);
    btn = b;
    vsync = 1'b0;
    for (int i = 0; i < lo; i++) begin
      collision = (cmode == 2 && i == 1);
      @(negedge clk);
    end
    collision = 1'b0;
    vsync = 1'b1;
    @(negedge clk);
    @(negedge clk);
    collision = (cmode == 1);
    @(negedge clk);
    collision = 1'b0;
    repeat (hi - 3) @(negedge clk);
    model_frame(b, cmode);
    check_model();
  endtask

  task automatic press_seq();
    frame(1'b0, 0);
    frame(1'b1, 0);
    frame(1'b1, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_start"},  32'(start),         0);
    check({tag, "_over"},   32'(game_over),     0);
    check({tag, "_offset"}, 32'(scroll_offset), 0);
    check({tag, "_speed"},  32'(speed),         SPEED_MIN);
    check({tag, "_star"},   32'(star_phase),    0);
    check({tag, "_score"},  32'(score),         0);
  endtask

  initial begin
    rst_n = 1'b0; vsync = 1'b0; btn = 1'b0; collision = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Idle frames: star toggles four times, nothing starts
    repeat (4) frame(1'b0, 0);
    check("idle4_star",   32'(star_phase),    0);
    check("idle4_start",  32'(start),         0);
    check("idle4_offset", 32'(scroll_offset), 0);

    // Single-frame press is rejected, two frames start the run
    frame(1'b1, 0);
    frame(1'b0, 0);
    check("short_press", 32'(start), 0);
    frame(1'b1, 0);
    frame(1'b1, 0);
    check("press_start",  32'(start),         1);
    check("press_offset", 32'(scroll_offset), 0);
    check("press_speed",  32'(speed),         1);

    // Long run through two speed increments
    repeat (1100) frame(1'b0, 0);
    check("run_speed",  32'(speed),         3);
    check("run_score",  32'(score),         1100);
    check("run_offset", 32'(scroll_offset), 740);

    // Collision before the tick, wait out the hold, back to idle and restart
    frame(1'b0, 2);
    check("coll1_over",  32'(game_over), 1);
    check("coll1_score", 32'(score),     1100);
    for (int i = 0; i < 100 && m_hold < HOLD; i++) frame(1'b0, 0);
    frame(1'b1, 0);
    frame(1'b1, 0);
    check("back_idle", 32'(game_over), 0);
    press_seq();
    check("restart1", 32'(start), 1);

    // Collision coincident with the frame tick at score 20
    repeat (20) frame(1'b0, 0);
    check("pre_coll_score", 32'(score), 20);
    frame(1'b0, 1);
    check("coll2_over",   32'(game_over),     1);
    check("coll2_score",  32'(score),         20);
    check("coll2_offset", 32'(scroll_offset), 20);
    repeat (10) frame(1'b0, 0);
    check("frozen_offset", 32'(scroll_offset), 20);

    // Early press during the hold is ignored
    for (int i = 0; i < 100 && m_hold < 28; i++) frame(1'b0, 0);
    frame(1'b1, 0);
    frame(1'b1, 0);
    check("early_press_over", 32'(game_over), 1);
    for (int i = 0; i < 100 && m_hold < HOLD; i++) frame(1'b0, 0);
    frame(1'b1, 0);
    frame(1'b1, 0);
    check("late_press_over",  32'(game_over), 0);
    check("late_press_score", 32'(score),     20);
    press_seq();
    check("restart2_start", 32'(start), 1);
    check("restart2_score", 32'(score), 0);

    // Asynchronous reset mid-run
    repeat (300) frame(1'b0, 0);
    check("pre_rst_offset", 32'(scroll_offset), 300);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (2) frame(1'b0, 0);
    check("post_rst_start", 32'(start), 0);
    press_seq();
    check("post_rst_run", 32'(start), 1);

    // Randomized play
    for (int n = 0; n < 300; n++) begin
      int r;
      int cm;
      r  = $urandom_range(0, 99);
      cm = (r < 4) ? 1 : ((r < 8) ? 2 : 0);
      frame(1'($urandom_range(0, 1)), cm);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
